div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Sequences one shared unsigned AXI-stream divider core for all four RV32M divide ops (DIV/DIVU/REM/REMU).
//  Sits in EX between decode and the divider: converts signed operands to magnitudes and fixes signs on the result.
//  Resolves the RISC-V divide-by-zero and overflow cases without using the core.
//  Drives the pipeline stall and discards in-flight results on flush.
// PARAMETERS
//  XLEN         32  operand/result width
//  WDOG_CYCLES  64  max cycles in S_ISSUE+S_WAIT before watchdog abort
// PORTS
//  clk                  in   1       clock, all logic on posedge
//  reset_n              in   1       asynchronous, active-low reset
//  ex_is_div            in   1       EX holds a divide op (held until stall drops)
//  funct3               in   3       100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a / b                in   XLEN    dividend / divisor
//  flush                in   1       squash the EX instruction
//  stall                out  1       freeze IF..EX
//  result               out  XLEN    final value, valid when result_valid
//  result_valid         out  1       1-cycle pulse with the final result
//  wdog_err             out  1       sticky; cleared only by reset
//  dvd_tvalid/tready/tdata  out/in/out  1/1/XLEN  core dividend channel
//  dvs_tvalid/tready/tdata  out/in/out  1/1/XLEN  core divisor channel
//  dout_tvalid          in   1       core result valid (core has no backpressure)
//  dout_tdata           in   2*XLEN  {remainder, quotient}, unsigned
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, operand/flag regs 0. Reset mid-op aborts immediately.
//  States:
//   S_IDLE: ex_is_div && !flush -> capture op, |a|, |b|, sign flags.
//     b==0 -> S_DONE (Q=all-ones, R=a).
//     signed && a==MIN && b==-1 -> S_DONE (Q=MIN, R=0).
//     else -> S_ISSUE.
//   S_ISSUE: dvd_tvalid, dvs_tvalid high. Each tvalid drops on its own handshake; never re-raised.
//     Both done -> S_WAIT. tdata stable while tvalid.
//   S_WAIT: dout_tvalid -> apply signs, register result -> S_DONE.
//   S_DONE: result_valid=1, stall=0 for exactly this cycle -> S_IDLE.
//     ex_is_div seen in S_DONE is the same op and is not re-captured.
//   S_DRAIN: entered from S_ISSUE/S_WAIT on flush. Finish any open handshakes.
//     Swallow one dout_tvalid without asserting result_valid -> S_IDLE.
//  stall = (S_IDLE && ex_is_div && !flush) | S_ISSUE | S_WAIT | S_DRAIN.
//  Latency: special case = 1 stall cycle. Normal = 1 + handshake + core latency + 1.
//  Sign fix (funct3[0]==0):
//   quotient is negated iff sign(a)!=sign(b); remainder is negated iff a<0.
//   Two's-complement, XLEN-bit wrap.
//  flush in S_IDLE: ignored (no capture). flush in S_DONE: result_valid suppressed.
//  flush and dout_tvalid in the same cycle: result dropped -> S_IDLE.
//  Watchdog counter runs in S_ISSUE/S_WAIT/S_DRAIN. On reaching WDOG_CYCLES: set wdog_err, force S_DONE with result=0.
// CONFIGURATION
//  DIV_RESULT_CACHE_EN defined:
//   Keeps the last {a, b, signed} and its {Q, R}. On a match in S_IDLE -> S_DONE (1 stall cycle), core not used.
//   The cache is invalidated by reset and by a watchdog abort. Cache entries come only from normal core results.
//  Not defined: no cache; every non-special op uses the core.
// STRUCTURE
//  div_pkg: state enum (S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN), funct3 constants, XLEN_MIN constant.
//  Sub-module div_sign_fix (combinational): operand magnitudes in; signed Q/R out.
// TESTING
//  DIV  a=-7,  b=2          -> result=-3 (0xFFFFFFFD); stall high until result_valid pulse.
//  REM  a=-7,  b=2          -> 0xFFFFFFFF. REMU a=7, b=2 -> 1.
//  DIVU a=5,   b=0          -> 0xFFFFFFFF after 1 stall cycle; REM a=5, b=0 -> 5; no tvalid issued.
//  DIV  a=0x80000000, b=-1  -> 0x80000000. REM same operands -> 0. Core untouched.
//  flush during S_WAIT      -> no result_valid; the late dout_tvalid is swallowed.
//   A following DIVU 100/7 returns 14.
//  Core holds tready low 10 cycles -> tvalid and tdata held stable.
//   Core never returns dout_tvalid -> wdog_err after 64 cycles; stall drops.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } dout_t;

    // Magnitude of x when interpreted as signed; unchanged for unsigned ops.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Restores signs on the unsigned core quotient/remainder for DIV and REM.
module div_sign_fix
    import div_pkg::*;
(
    input  logic [XLEN-1:0] q_mag,
    input  logic [XLEN-1:0] r_mag,
    input  logic            is_signed,
    input  logic            a_neg,
    input  logic            b_neg,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    assign q = (is_signed && (a_neg ^ b_neg)) ? (~q_mag + 1'b1) : q_mag;
    assign r = (is_signed && a_neg) ? (~r_mag + 1'b1) : r_mag;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequences a shared unsigned AXI-stream divider core for DIV/DIVU/REM/REMU.
// Optional last-result cache is enabled by defining DIV_RESULT_CACHE_EN.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_is_div,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic              stall,
    output logic [XLEN-1:0]   result,
    output logic              result_valid,
    output logic              wdog_err,
    output logic              dvd_tvalid,
    input  logic              dvd_tready,
    output logic [XLEN-1:0]   dvd_tdata,
    output logic              dvs_tvalid,
    input  logic              dvs_tready,
    output logic [XLEN-1:0]   dvs_tdata,
    input  logic              dout_tvalid,
    input  logic [2*XLEN-1:0] dout_tdata
);

    localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);

    state_t          state, state_n;
    logic            is_rem, is_rem_n, is_sgn, is_sgn_n;
    logic            a_neg, a_neg_n, b_neg, b_neg_n;
    logic [XLEN-1:0] mag_a, mag_a_n, mag_b, mag_b_n, res_q, res_n;
    logic            dvd_pend, dvd_pend_n, dvs_pend, dvs_pend_n;
    logic            wdog_q, abort;
    logic [WCW-1:0]  wcnt, wcnt_n;
    logic            cap_rem, cap_sgn, cache_hit;
    logic [XLEN-1:0] cache_val, q_fix, r_fix;
    dout_t           dout;

    assign dout    = dout_tdata;
    assign cap_rem = (funct3 == F3_REM) || (funct3 == F3_REMU);
    assign cap_sgn = (funct3 == F3_DIV) || (funct3 == F3_REM);

    div_sign_fix u_sign_fix (
        .q_mag     (dout.quo),
        .r_mag     (dout.rem),
        .is_signed (is_sgn),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .q         (q_fix),
        .r         (r_fix)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_vld, cache_sgn;
    logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r, op_a, op_b;

    // Only normal core completions populate the cache; a watchdog abort empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld <= 1'b0;
            cache_sgn <= 1'b0;
            cache_a   <= '0;
            cache_b   <= '0;
            cache_q   <= '0;
            cache_r   <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            if (state == S_IDLE && ex_is_div && !flush) begin
                op_a <= a;
                op_b <= b;
            end
            if (abort) begin
                cache_vld <= 1'b0;
            end else if (state == S_WAIT && dout_tvalid && !flush) begin
                cache_vld <= 1'b1;
                cache_sgn <= is_sgn;
                cache_a   <= op_a;
                cache_b   <= op_b;
                cache_q   <= q_fix;
                cache_r   <= r_fix;
            end
        end
    end

    assign cache_hit = cache_vld && (a == cache_a) && (b == cache_b) && (cap_sgn == cache_sgn);
    assign cache_val = cap_rem ? cache_r : cache_q;
`else
    assign cache_hit = 1'b0;
    assign cache_val = '0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_n    = state;
        is_rem_n   = is_rem;
        is_sgn_n   = is_sgn;
        a_neg_n    = a_neg;
        b_neg_n    = b_neg;
        mag_a_n    = mag_a;
        mag_b_n    = mag_b;
        res_n      = res_q;
        dvd_pend_n = dvd_pend;
        dvs_pend_n = dvs_pend;
        wcnt_n     = wcnt;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ex_is_div && !flush) begin
                    is_rem_n = cap_rem;
                    is_sgn_n = cap_sgn;
                    a_neg_n  = a[XLEN-1];
                    b_neg_n  = b[XLEN-1];
                    mag_a_n  = mag(a, cap_sgn);
                    mag_b_n  = mag(b, cap_sgn);
                    wcnt_n   = '0;
                    if (b == '0) begin
                        res_n   = cap_rem ? a : '1;
                        state_n = S_DONE;
                    end else if (cap_sgn && (a == XLEN_MIN) && (b == '1)) begin
                        res_n   = cap_rem ? '0 : XLEN_MIN;
                        state_n = S_DONE;
                    end else if (cache_hit) begin
                        res_n   = cache_val;
                        state_n = S_DONE;
                    end else begin
                        dvd_pend_n = 1'b1;
                        dvs_pend_n = 1'b1;
                        state_n    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (dvd_tready) dvd_pend_n = 1'b0;
                if (dvs_tready) dvs_pend_n = 1'b0;
                wcnt_n = wcnt + 1'b1;
                if (flush) begin
                    state_n = S_DRAIN;
                end else if (!dvd_pend_n && !dvs_pend_n) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                wcnt_n = wcnt + 1'b1;
                if (dout_tvalid) begin
                    if (flush) begin
                        state_n = S_IDLE;
                    end else begin
                        res_n   = is_rem ? r_fix : q_fix;
                        state_n = S_DONE;
                    end
                end else if (flush) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dvd_tready) dvd_pend_n = 1'b0;
                if (dvs_tready) dvs_pend_n = 1'b0;
                wcnt_n = wcnt + 1'b1;
                if (dout_tvalid) begin
                    dvd_pend_n = 1'b0;
                    dvs_pend_n = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Watchdog: abandon the core if it has not finished within the budget.
        if ((state inside {S_ISSUE, S_WAIT, S_DRAIN}) &&
            (state_n inside {S_ISSUE, S_WAIT, S_DRAIN}) && (wcnt == WDOG_LAST)) begin
            abort      = 1'b1;
            state_n    = S_DONE;
            res_n      = '0;
            dvd_pend_n = 1'b0;
            dvs_pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            is_rem   <= 1'b0;
            is_sgn   <= 1'b0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            res_q    <= '0;
            dvd_pend <= 1'b0;
            dvs_pend <= 1'b0;
            wcnt     <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state    <= state_n;
            is_rem   <= is_rem_n;
            is_sgn   <= is_sgn_n;
            a_neg    <= a_neg_n;
            b_neg    <= b_neg_n;
            mag_a    <= mag_a_n;
            mag_b    <= mag_b_n;
            res_q    <= res_n;
            dvd_pend <= dvd_pend_n;
            dvs_pend <= dvs_pend_n;
            wcnt     <= wcnt_n;
            wdog_q   <= wdog_q | abort;
        end
    end

    // The capture-cycle stall must be combinational so the pipeline freezes immediately.
    assign stall        = ((state == S_IDLE) && ex_is_div && !flush) ||
                          (state inside {S_ISSUE, S_WAIT, S_DRAIN});
    assign result_valid = (state == S_DONE) && !flush;
    assign result       = res_q;
    assign wdog_err     = wdog_q;
    assign dvd_tvalid   = dvd_pend;
    assign dvs_tvalid   = dvs_pend;
    assign dvd_tdata    = mag_a;
    assign dvs_tdata    = mag_b;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed vector table, corner sequences and random ops vs a reference model.
module tb_div_seq_ctrl;

    logic        clk, reset_n, ex_is_div, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b, result, dvd_tdata, dvs_tdata;
    logic        stall, result_valid, wdog_err;
    logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready, dout_tvalid;
    logic [63:0] dout_tdata;

    div_seq_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_is_div    (ex_is_div),
        .funct3       (funct3),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid),
        .wdog_err     (wdog_err),
        .dvd_tvalid   (dvd_tvalid),
        .dvd_tready   (dvd_tready),
        .dvd_tdata    (dvd_tdata),
        .dvs_tvalid   (dvs_tvalid),
        .dvs_tready   (dvs_tready),
        .dvs_tdata    (dvs_tdata),
        .dout_tvalid  (dout_tvalid),
        .dout_tdata   (dout_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int rdy_delay = 0;
    int core_lat = 0;
    bit core_drop = 1'b0;
    bit chk_mag = 1'b0;
    logic [31:0] exp_md = '0;
    logic [31:0] exp_ms = '0;
    int tv_seen = 0;
    int hs_wait_d = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    endtask

    task automatic bad(input string nm, input string msg);
        n_chk++;
        $display("FAIL %s: %s", nm, msg);
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        int signed sx, sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return f3[1] ? x : 32'hFFFF_FFFF;
        if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3)
            3'b100:  return 32'(sx / sy);
            3'b101:  return x / y;
            3'b110:  return 32'(sx % sy);
            default: return x % y;
        endcase
    endfunction

    // Divider core model: programmable tready delay, fixed latency, optional no-response.
    initial begin : core_bfm
        int cnt_d, cnt_s, lat_cnt;
        bit got_d, got_s, busy, nd, ns;
        logic [31:0] cd, cs, q, r;
        cnt_d = 0; cnt_s = 0; lat_cnt = 0;
        got_d = 0; got_s = 0; busy = 0;
        cd = '0; cs = '0; q = '0; r = '0;
        dvd_tready = 1'b0; dvs_tready = 1'b0; dout_tvalid = 1'b0; dout_tdata = '0;
        forever begin
            @(negedge clk);
            if (dvd_tvalid || dvs_tvalid) tv_seen++;
            if (chk_mag && dvd_tvalid) check("dvd_tdata_stable", dvd_tdata, exp_md);
            if (chk_mag && dvs_tvalid) check("dvs_tdata_stable", dvs_tdata, exp_ms);
            if (dvd_tvalid && dvd_tready) begin got_d = 1; cd = dvd_tdata; hs_wait_d = cnt_d; end
            if (dvs_tvalid && dvs_tready) begin got_s = 1; cs = dvs_tdata; end
            nd = dvd_tvalid && !dvd_tready;
            ns = dvs_tvalid && !dvs_tready;
            @(posedge clk); #1;
            dout_tvalid = 1'b0;
            cnt_d = nd ? cnt_d + 1 : 0;
            cnt_s = ns ? cnt_s + 1 : 0;
            dvd_tready = (rdy_delay == 0) || (cnt_d >= rdy_delay);
            dvs_tready = (rdy_delay == 0) || (cnt_s >= rdy_delay);
            if (got_d && got_s && !busy) begin
                busy = 1; lat_cnt = core_lat; got_d = 0; got_s = 0;
                q = (cs == 0) ? 32'hFFFF_FFFF : cd / cs;
                r = (cs == 0) ? cd : cd % cs;
            end
            if (busy) begin
                if (lat_cnt == 0) begin
                    busy = 0;
                    if (!core_drop) begin dout_tvalid = 1'b1; dout_tdata = {r, q}; end
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    // One op through EX; lat>=0 checks stall-cycle count, lat==1 also checks the core stayed idle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ex, input int lat, input string nm);
        int sc, tv0;
        bit done;
        sc = 0; done = 0; tv0 = tv_seen;
        @(posedge clk); #1;
        ex_is_div = 1'b1; funct3 = f3; a = av; b = bv;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (result_valid) begin
                done = 1;
                check({nm, "_result"}, result, ex);
                check({nm, "_stall_in_done"}, 32'(stall), 32'd0);
                if (lat >= 0) check({nm, "_stall_cycles"}, 32'(sc), 32'(lat));
                if (lat == 1) check({nm, "_core_idle"}, 32'(tv_seen - tv0), 32'd0);
            end else if (stall) begin
                sc++;
            end else begin
                done = 1;
                bad(nm, "stall=0 before result_valid, want stall=1 until result");
            end
        end
        if (!done) bad(nm, "result_valid=0 after 200 cycles, want 1");
        @(posedge clk); #1;
        ex_is_div = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin : global_guard
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int rv_cnt, st_cnt;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int sel;

        vecs[0]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 3};
        vecs[1]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, -1};
        vecs[2]  = '{3'b111, 32'd7,         32'd2,        32'd1,         -1};
        vecs[3]  = '{3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 1};
        vecs[4]  = '{3'b110, 32'd5,         32'd0,        32'd5,         1};
        vecs[5]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[6]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vecs[7]  = '{3'b101, 32'd100,       32'd7,        32'd14,        -1};
        vecs[8]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, -1};
        vecs[9]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         -1};
        vecs[10] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         -1};
        vecs[11] = '{3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, -1};
        vecs[12] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         -1};
        vecs[13] = '{3'b100, 32'd5,         32'd0,        32'hFFFF_FFFF, 1};

        reset_n = 1'b0; ex_is_div = 1'b0; flush = 1'b0; funct3 = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_wdog_err", 32'(wdog_err), 32'd0);
        check("rst_tvalid", {30'd0, dvd_tvalid, dvs_tvalid}, 32'd0);

        // flush in idle: no capture
        @(posedge clk); #1;
        ex_is_div = 1'b1; flush = 1'b1; funct3 = 3'b101; a = 32'd10; b = 32'd2;
        @(negedge clk);
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ex_is_div = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush_no_issue", {30'd0, dvd_tvalid, result_valid}, 32'd0);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].f3, vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

        // flush while waiting on the core: late result must be swallowed
        core_lat = 5;
        @(posedge clk); #1;
        ex_is_div = 1'b1; funct3 = 3'b101; a = 32'd50; b = 32'd3;
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1; ex_is_div = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        rv_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) rv_cnt++;
            if (stall) st_cnt++;
        end
        check("flush_wait_no_result_valid", 32'(rv_cnt), 32'd0);
        check("flush_wait_drain_cycles", 32'(st_cnt), 32'd4);
        core_lat = 0;
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 3, "after_flush_divu");

        // flush in the same cycle as dout_tvalid
        @(posedge clk); #1;
        ex_is_div = 1'b1; funct3 = 3'b101; a = 32'd20; b = 32'd3;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1; ex_is_div = 1'b0;
        @(negedge clk);
        check("flush_dout_rv", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_dout_idle", {30'd0, stall, result_valid}, 32'd0);
        run_op(3'b111, 32'd20, 32'd3, 32'd2, -1, "after_flush_dout");

        // tready held low for 10 cycles
        rdy_delay = 10; exp_md = 32'd100; exp_ms = 32'd7; chk_mag = 1'b1;
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 13, "tready_hold");
        chk_mag = 1'b0;
        check("tready_hold_wait", 32'(hs_wait_d), 32'd10);
        rdy_delay = 0;

        // randomized ops vs reference model
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(4, 7));
            ra = $urandom; rb = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel < 5) rb = $urandom_range(1, 20);
            else if (sel == 5) begin ra = $urandom_range(0, 100); rb = 32'hFFFF_FFFF - $urandom_range(0, 9); end
            rdy_delay = int'($urandom_range(0, 3));
            core_lat = int'($urandom_range(0, 4));
            run_op(rf3, ra, rb, ref_div(rf3, ra, rb), -1, $sformatf("rand%0d", i));
        end
        rdy_delay = 0; core_lat = 0;

        // core never answers: watchdog abort
        core_drop = 1'b1;
        run_op(3'b101, 32'd9, 32'd3, 32'd0, 65, "wdog");
        @(negedge clk);
        check("wdog_err_set", 32'(wdog_err), 32'd1);
        core_drop = 1'b0;
        run_op(3'b101, 32'd9, 32'd3, 32'd3, -1, "after_wdog");
        @(negedge clk);
        check("wdog_err_sticky", 32'(wdog_err), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
